// File: rtl/uart_tx_buffered.sv
// Buffered 8N1/8N2 UART transmitter: producers push bytes into a small FIFO,
// and the serialiser drains it frame after frame with no idle gap between queued bytes.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_en,
    input  logic [7:0]         i_wr_byte,
    output logic               o_full,
    output logic               o_empty,
    output logic [FIFO_AW:0]   o_count,
    output logic               o_overflow,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]  BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0]  BAUD_ZERO = BAUD_W'(0);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0]   CNT_ZERO  = (FIFO_AW+1)'(0);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW+1)'(2**FIFO_AW);
    localparam logic [2:0]         STOP_LAST = 3'(STOP_BITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]         r_mem [0:(2**FIFO_AW)-1];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;
    logic [1:0]         r_state;
    logic [BAUD_W-1:0]  r_baud;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;

    logic               w_baud_last;
    logic               w_stop_last;
    logic               w_pop;
    logic               w_push;
    logic [FIFO_AW:0]   w_count_nxt;

    // Handshake decode; a push is judged on the registered full flag, so a
    // write on a full FIFO is dropped even when a pop happens in that cycle.
    always_comb begin
        w_baud_last = (r_baud == BAUD_LAST);
        w_stop_last = (r_state == ST_STOP) && w_baud_last && (r_idx == STOP_LAST);
        w_pop       = !r_empty && ((r_state == ST_IDLE) || w_stop_last);
        w_push      = i_wr_en && !r_full;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_byte;
        end
    end

    // FIFO pointers, occupancy and status flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= CNT_ZERO;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CNT_FULL);
            r_empty    <= (w_count_nxt == CNT_ZERO);
            r_overflow <= i_wr_en && r_full;
        end
    end

    // Frame sequencer; r_idx counts data bits in DATA and stop bits in STOP
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_baud  <= BAUD_ZERO;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud <= BAUD_ZERO;
                    r_idx  <= 3'd0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_last) begin
                        r_baud  <= BAUD_ZERO;
                        r_idx   <= 3'd0;
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= BAUD_ZERO;
                        r_idx  <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_idx   <= 3'd0;
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (w_baud_last) begin
                        r_baud <= BAUD_ZERO;
                        r_idx  <= r_idx + 3'd1;
                        if (r_idx == STOP_LAST) begin
                            r_idx <= 3'd0;
                            if (w_pop) begin
                                r_shift <= r_mem[r_rd_ptr];
                                r_state <= ST_START;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_baud  <= BAUD_ZERO;
                    r_idx   <= 3'd0;
                end
            endcase
        end
    end

    // Line outputs lag the sequencer by one cycle so tx, busy and done stay mutually aligned
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            case (r_state)
                ST_START: r_tx <= 1'b0;
                ST_DATA:  r_tx <= r_shift[r_idx];
                default:  r_tx <= 1'b1;
            endcase
            r_busy <= (r_state != ST_IDLE);
            r_done <= w_stop_last;
        end
    end

    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_tx       = r_tx;
    assign o_tx_busy  = r_busy;
    assign o_tx_done  = r_done;

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered UART transmitter: the sending end of the serial link carried by the uart/fifo loopback path.
- Accepts bytes from on-chip producers into an internal FIFO, then serialises them 8N1 (or 8N2) LSB-first on o_tx at a fixed baud rate.
- Replaces the bare tx-byte handshake so producers can burst bytes without tracking o_tx_busy.

Parameters:
- CLKS_PER_BIT, 868, i_clk cycles per serial bit (100 MHz / 115200); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 bytes.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_wr_en  input  1  write strobe; byte accepted on the rising edge when i_wr_en=1 and o_full=0.
- i_wr_byte  input  8  byte to enqueue.
- o_full  output  1  FIFO holds 2**FIFO_AW bytes.
- o_empty  output  1  FIFO holds 0 bytes.
- o_count  output  FIFO_AW+1  bytes currently queued; excludes the byte being shifted.
- o_overflow  output  1  one-cycle pulse when i_wr_en=1 while o_full=1; the byte is dropped.
- o_tx  output  1  serial line, registered, idle high.
- o_tx_busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.
- o_tx_done  output  1  one-cycle pulse on the final cycle of each frame's last stop bit.

Behaviour:
- Reset (async assert, sync release):
  - o_tx=1, o_tx_busy=0, o_tx_done=0, o_overflow=0.
  - o_full=0, o_empty=1, o_count=0.
  - FIFO pointers, baud counter, bit index and FSM (IDLE) cleared.
  - Reset mid-frame aborts the frame immediately; o_tx returns high and queued bytes are discarded.
- FIFO:
  - Circular buffer with separate wr/rd pointers of FIFO_AW bits that wrap naturally; count register of FIFO_AW+1 bits.
  - o_full, o_empty and o_count are registered and derived from the count.
  - Write is accepted iff i_wr_en & !o_full, using the registered o_full. A write on a full FIFO is dropped even if a pop occurs in the same cycle.
  - Simultaneous write and pop: count is unchanged and both pointers advance.
- FSM states and transitions:
  - IDLE: o_tx=1. If !o_empty, pop the head into the shift register and go to START on the next edge.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: o_tx=shift[idx] for CLKS_PER_BIT cycles per bit, LSB first. After idx=7 go to STOP.
  - STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, pulse o_tx_done. If FIFO is non-empty, pop in that same cycle and enter START next edge, so there is no idle gap. Otherwise return to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, resets to 0 on each bit boundary.
  - Width is ceil(log2(CLKS_PER_BIT)) bits.
- Latency: a write into an empty FIFO while idle gives o_empty=0 at edge N+1, the pop at edge N+2, and o_tx falling at edge N+3.
- o_tx_busy is 1 in START, DATA and STOP; 0 in IDLE.
- Frame length: (10 + STOP_BITS - 1) * CLKS_PER_BIT cycles.
- The popped byte is held in the shift register. New FIFO writes never alter the in-flight frame.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4: o_tx stays 1, o_empty=1 and o_tx_busy=0 for 100 cycles.
- Single write 0xA5, CLKS_PER_BIT=4:
  - o_tx shows start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit 4 cycles.
  - o_tx_done pulses once, 40 cycles after the start edge; o_tx_busy is high for exactly 40 cycles.
- Burst of 16 writes 0x00..0x0F on consecutive cycles:
  - o_full=1 once the count reaches 16, or 15 if the first pop has already occurred; the bench checks o_count each cycle.
  - A 17th write while o_full pulses o_overflow and is dropped.
  - All accepted bytes appear in order, back-to-back with no idle gap; 16 o_tx_done pulses.
- Simultaneous write and pop with count=3: o_count stays 3, and the written byte is transmitted fourth.
- STOP_BITS=2, write 0xFF: stop phase lasts 8 cycles at CLKS_PER_BIT=4; frame is 44 cycles.
- Assert i_rst_n=0 during DATA bit 3 with 5 bytes queued:
  - o_tx=1, o_tx_busy=0, o_count=0 and o_empty=1 immediately.
  - After release, no frame is emitted.
